// File: rtl/sequencer.sv
// -----------------------------------------------------------------------------
// sequencer -- upstream control FSM for the core.
//
// Steps the core through SREAD -> SLOAD1 -> SLOAD2 -> SCALC -> SWRITE for each
// instruction line. It also handles:
//   - run/stop control at instruction boundaries,
//   - RAM-busy stalls, guarded by a watchdog that forces SERR,
//   - HALT detection (by opcode, or by retiring the last line),
//   - a saturating count of retired instructions.
//
// Ports
//   clk          in   1              system clock, all state on posedge
//   rst          in   1              synchronous active-high reset
//   run          in   1              1 = execute, 0 = park in SRST at next boundary
//   ram_busy     in   1              RAM busy, from RAM
//   opcode       in   OPCODE_WIDTH   current instruction opcode (sampled in SCALC)
//   ip           in   IP_WIDTH       current line pointer (sampled at SWRITE exit)
//   q            out  SequencerState state to core
//   err          out  1              1 while q==SERR
//   halted       out  1              1 while q==SHALT
//   stall        out  1              1 while q is held by ram_busy
//   instr_count  out  CNT_WIDTH      retired instructions since reset, saturating
// -----------------------------------------------------------------------------
package sequencer_pkg;
  typedef enum logic [2:0] {
    SRST   = 3'd0,
    SREAD  = 3'd1,
    SLOAD1 = 3'd2,
    SLOAD2 = 3'd3,
    SCALC  = 3'd4,
    SWRITE = 3'd5,
    SHALT  = 3'd6,
    SERR   = 3'd7
  } SequencerState;
endpackage

module sequencer
  import sequencer_pkg::*;
#(
  parameter int OPCODE_WIDTH                = 8,
  parameter int IP_WIDTH                    = 8,
  parameter int BUSY_TIMEOUT                = 16,
  parameter int CNT_WIDTH                   = 16,
  parameter logic [OPCODE_WIDTH-1:0] OP_HALT = {OPCODE_WIDTH{1'b1}},
  parameter logic [IP_WIDTH-1:0]     IP_LAST = {IP_WIDTH{1'b1}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    ram_busy,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [IP_WIDTH-1:0]     ip,
  output SequencerState           q,
  output logic                    err,
  output logic                    halted,
  output logic                    stall,
  output logic [CNT_WIDTH-1:0]    instr_count
);

  // Wide enough to hold BUSY_TIMEOUT-1 even when BUSY_TIMEOUT is a power of two.
  localparam int BC_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [BC_W-1:0] BUSY_LAST = BC_W'(BUSY_TIMEOUT - 1);

  SequencerState          q_q, q_d;
  logic [BC_W-1:0]        busy_cnt_q, busy_cnt_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   err_q, halted_q;
  logic                   ram_state;

  // Only the states that touch RAM can be held by ram_busy.
  assign ram_state = (q_q == SLOAD1) || (q_q == SLOAD2) || (q_q == SWRITE);
  assign stall     = ram_busy & ram_state;

  always_comb begin
    q_d        = q_q;
    busy_cnt_d = busy_cnt_q;
    cnt_d      = cnt_q;

    if (stall) begin
      // The watchdog fires on the BUSY_TIMEOUT-th consecutive held cycle,
      // overriding the hold.
      if (busy_cnt_q == BUSY_LAST) begin
        q_d        = SERR;
        busy_cnt_d = '0;
      end else begin
        busy_cnt_d = busy_cnt_q + BC_W'(1);
      end
    end else begin
      busy_cnt_d = '0;
      unique case (q_q)
        SRST:   q_d = run ? SREAD : SRST;
        SREAD:  q_d = SLOAD1;
        SLOAD1: q_d = SLOAD2;
        SLOAD2: q_d = SCALC;
        SCALC:  q_d = (opcode == OP_HALT) ? SHALT : SWRITE;
        SWRITE: begin
          // Retiring the line, including the last one that leads to SHALT.
          if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_WIDTH'(1);
          if (ip == IP_LAST)  q_d = SHALT;
          else if (run)       q_d = SREAD;
          else                q_d = SRST;
        end
        SHALT:  q_d = SHALT;
        SERR:   q_d = SERR;
        default: q_d = SERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= SRST;
      busy_cnt_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      q_q        <= q_d;
      busy_cnt_q <= busy_cnt_d;
      cnt_q      <= cnt_d;
      // Flags register alongside q so they never depend on inputs combinationally.
      err_q      <= (q_d == SERR);
      halted_q   <= (q_d == SHALT);
    end
  end

  assign q           = q_q;
  assign err         = err_q;
  assign halted      = halted_q;
  assign instr_count = cnt_q;

endmodule
